// File: rtl/lcd_fill_sequencer.sv
// Bus-master sequencer feeding an SPI controller register port: optional panel init,
// full-screen window programming, then a single-colour RGB565 fill.
module lcd_fill_sequencer #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320,
  parameter int DELAY_CYCLES = 12_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] color_in,
  output logic [31:0] address_out,
  output logic        sel_out,
  output logic        read_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  output logic        busy,
  output logic        done
);

  localparam int          NPIX     = WIDTH * HEIGHT;
  localparam int          PIX_W    = $clog2(NPIX + 1);
  localparam int          DLY_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [15:0] W_LAST   = 16'(WIDTH - 1);
  localparam logic [15:0] H_LAST   = 16'(HEIGHT - 1);
  localparam logic [4:0]  STEP_RUN = 5'd5;
  localparam logic [4:0]  STEP_PIX = 5'd16;
  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_CTRL   = 32'h4;
  localparam logic [31:0] A_STATUS = 32'h8;
  localparam logic [31:0] A_DC     = 32'hC;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WR_DC, S_WR_DATA, S_WR_CTRL,
    S_POLL, S_POLL_GAP, S_NEXT, S_DELAY, S_FINISH
  } state_t;

  state_t             state_q;
  logic [4:0]         step_q;
  logic [PIX_W-1:0]   pix_q;
  logic               phase_q;
  logic [15:0]        color_q;
  logic [7:0]         byte_q;
  logic [DLY_W-1:0]   dly_q;
  logic               init_done_q;
  logic               sel_q, read_q, busy_q, done_q;
  logic [3:0]         mask_q;
  logic [31:0]        addr_q, wdata_q;
  logic               dc_d;
  logic [7:0]         byte_d;
  logic               unused_rd;

  assign unused_rd       = ^read_value_in[31:1];
  assign address_out     = addr_q;
  assign sel_out         = sel_q;
  assign read_out        = read_q;
  assign write_mask_out  = mask_q;
  assign write_value_out = wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;

  // Steps 0-4 are the init list, 5-15 the window setup, 16 the pixel stream.
  always_comb begin
    dc_d   = 1'b1;
    byte_d = 8'h00;
    case (step_q)
      5'd0:  begin dc_d = 1'b0; byte_d = 8'h01; end
      5'd1:  begin dc_d = 1'b0; byte_d = 8'h11; end
      5'd2:  begin dc_d = 1'b0; byte_d = 8'h3A; end
      5'd3:  byte_d = 8'h55;
      5'd4:  begin dc_d = 1'b0; byte_d = 8'h29; end
      5'd5:  begin dc_d = 1'b0; byte_d = 8'h2A; end
      5'd8:  byte_d = W_LAST[15:8];
      5'd9:  byte_d = W_LAST[7:0];
      5'd10: begin dc_d = 1'b0; byte_d = 8'h2B; end
      5'd13: byte_d = H_LAST[15:8];
      5'd14: byte_d = H_LAST[7:0];
      5'd15: begin dc_d = 1'b0; byte_d = 8'h2C; end
      5'd16: byte_d = phase_q ? color_q[7:0] : color_q[15:8];
      default: byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      pix_q       <= '0;
      phase_q     <= 1'b0;
      dly_q       <= '0;
      init_done_q <= 1'b0;
      sel_q       <= 1'b0;
      read_q      <= 1'b0;
      mask_q      <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q  <= 1'b1;
          color_q <= color_in;
          step_q  <= init_done_q ? STEP_RUN : 5'd0;
          pix_q   <= '0;
          phase_q <= 1'b0;
          state_q <= S_LOAD;
        end
        // LOAD both latches the byte and launches the DC write, saving a gap cycle.
        S_LOAD: begin
          byte_q  <= byte_d;
          sel_q   <= 1'b1;
          read_q  <= 1'b0;
          mask_q  <= 4'hF;
          addr_q  <= A_DC;
          wdata_q <= {31'b0, dc_d};
          state_q <= S_WR_DC;
        end
        S_WR_DC: if (ready_in) begin
          sel_q   <= 1'b0;
          mask_q  <= 4'h0;
          state_q <= S_WR_DATA;
        end
        S_WR_DATA: if (!sel_q) begin
          sel_q   <= 1'b1;
          mask_q  <= 4'hF;
          addr_q  <= A_DATA;
          wdata_q <= {24'b0, byte_q};
        end else if (ready_in) begin
          sel_q   <= 1'b0;
          mask_q  <= 4'h0;
          state_q <= S_WR_CTRL;
        end
        S_WR_CTRL: if (!sel_q) begin
          sel_q   <= 1'b1;
          mask_q  <= 4'hF;
          addr_q  <= A_CTRL;
          wdata_q <= 32'd1;
        end else if (ready_in) begin
          sel_q   <= 1'b0;
          mask_q  <= 4'h0;
          state_q <= S_POLL;
        end
        S_POLL: if (!sel_q) begin
          sel_q   <= 1'b1;
          read_q  <= 1'b1;
          addr_q  <= A_STATUS;
          wdata_q <= '0;
        end else if (ready_in) begin
          sel_q   <= 1'b0;
          read_q  <= 1'b0;
          state_q <= read_value_in[0] ? S_POLL_GAP : S_NEXT;
        end
        S_POLL_GAP: begin
          sel_q   <= 1'b1;
          read_q  <= 1'b1;
          state_q <= S_POLL;
        end
        S_NEXT: begin
          if (step_q == 5'd4) init_done_q <= 1'b1;
          if (step_q != STEP_PIX) begin
            step_q <= step_q + 5'd1;
            if (step_q == 5'd0 || step_q == 5'd1) begin
              dly_q   <= DLY_W'(DELAY_CYCLES - 1);
              state_q <= S_DELAY;
            end else begin
              state_q <= S_LOAD;
            end
          end else begin
            phase_q <= ~phase_q;
            if (phase_q && pix_q == PIX_W'(NPIX - 1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              if (phase_q) pix_q <= pix_q + 1'b1;
              state_q <= S_LOAD;
            end
          end
        end
        S_DELAY: if (dly_q == '0) state_q <= S_LOAD;
                 else dly_q <= dly_q - 1'b1;
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
// Scoreboard bench for lcd_fill_sequencer on a 2x2 panel with a modelled SPI controller slave.
module tb_lcd_fill_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] color_in = 16'h0;
  logic [31:0] address_out, write_value_out, read_value_in;
  logic        sel_out, read_out, ready_in, busy, done;
  logic [3:0]  write_mask_out;

  lcd_fill_sequencer #(.WIDTH(2), .HEIGHT(2), .DELAY_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .color_in(color_in),
    .address_out(address_out), .sel_out(sel_out), .read_out(read_out),
    .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .read_value_in(read_value_in), .ready_in(ready_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller slave model: latency per access, STATUS busy for busy_cfg reads after each CTRL write.
  int lat_max = 0;
  int busy_cfg = 0;
  int wait_cnt, cur_lat, status_left;

  assign ready_in      = sel_out && (wait_cnt >= cur_lat);
  assign read_value_in = {16'hA5A5, 15'b0, status_left != 0};

  always @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 0; cur_lat <= 0; status_left <= 0;
    end else if (sel_out) begin
      if (ready_in) begin
        wait_cnt <= 0;
        cur_lat  <= (lat_max == 0) ? 0 : int'($urandom_range(lat_max, 0));
        if (!read_out && address_out == 32'h4 && write_value_out[0]) status_left <= busy_cfg;
        else if (read_out && status_left != 0) status_left <= status_left - 1;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Scoreboard monitor
  logic [8:0]  exp_q[$];
  logic [8:0]  exp_b;
  logic        dc_sh;
  logic [7:0]  data_sh;
  logic [31:0] held_addr, held_wdata;
  logic        hold_pend, ack_prev, prev_sel, prev_busy_rd, pend_dly, arm_dly, poll_clear;
  int          idle_cnt, reads_cnt, byte_cnt = 0, done_cnt = 0;
  int          run_gen = 0, ctrl_gen = -1;

  always @(posedge clk) begin
    if (reset) begin
      hold_pend = 0; ack_prev = 0; prev_sel = 0; prev_busy_rd = 0;
      pend_dly = 0; arm_dly = 0; poll_clear = 1; idle_cnt = 0; reads_cnt = 0;
    end else begin
      check("mask", {28'b0, write_mask_out}, (sel_out && !read_out) ? 32'hF : 32'h0);
      if (hold_pend)
        check("hold_stable", {sel_out, address_out[7:0], write_value_out[22:0]},
              {1'b1, held_addr[7:0], held_wdata[22:0]});
      if (ack_prev) check("sel_drop", {31'b0, sel_out}, 32'd0);
      if (sel_out && !prev_sel) begin
        if (arm_dly) begin
          check("delay_gap_ge16", {31'b0, idle_cnt >= 16}, 32'd1);
          arm_dly = 0;
        end
        if (read_out && prev_busy_rd) check("poll_gap", idle_cnt, 32'd1);
      end
      if (sel_out && ready_in) begin
        if (!read_out) begin
          prev_busy_rd = 0;
          if (address_out == 32'hC) begin
            dc_sh = write_value_out[0];
            if (ctrl_gen == run_gen) begin
              check("poll_clear_before_dc", {31'b0, poll_clear}, 32'd1);
              check("status_reads", reads_cnt, busy_cfg + 1);
            end
          end else if (address_out == 32'h0) begin
            data_sh = write_value_out[7:0];
          end else if (address_out == 32'h4) begin
            byte_cnt++;
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_byte actual=%h required=none", {dc_sh, data_sh});
            end else begin
              exp_b = exp_q.pop_front();
              check("byte", {23'b0, dc_sh, data_sh}, {23'b0, exp_b});
            end
            if (!dc_sh && (data_sh == 8'h01 || data_sh == 8'h11)) pend_dly = 1;
            ctrl_gen = run_gen; reads_cnt = 0; poll_clear = 0;
          end
        end else begin
          reads_cnt++;
          prev_busy_rd = read_value_in[0];
          if (!read_value_in[0]) begin
            poll_clear = 1;
            if (pend_dly) begin arm_dly = 1; pend_dly = 0; end
          end
        end
      end
      if (done) done_cnt++;
      idle_cnt   = sel_out ? 0 : idle_cnt + 1;
      prev_sel   = sel_out;
      hold_pend  = sel_out && !ready_in;
      ack_prev   = sel_out && ready_in;
      held_addr  = address_out;
      held_wdata = write_value_out;
    end
  end

  task automatic push(input logic dc, input logic [7:0] b);
    exp_q.push_back({dc, b});
  endtask

  task automatic push_run(input bit with_init, input logic [15:0] c);
    if (with_init) begin
      push(0, 8'h01); push(0, 8'h11); push(0, 8'h3A); push(1, 8'h55); push(0, 8'h29);
    end
    push(0, 8'h2A); push(1, 8'h00); push(1, 8'h00); push(1, 8'h00); push(1, 8'h01);
    push(0, 8'h2B); push(1, 8'h00); push(1, 8'h00); push(1, 8'h00); push(1, 8'h01);
    push(0, 8'h2C);
    for (int i = 0; i < 4; i++) begin
      push(1, c[15:8]); push(1, c[7:0]);
    end
  endtask

  task automatic pulse_start(input logic [15:0] c);
    @(negedge clk);
    color_in = c; start = 1'b1;
    run_gen++;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        check("busy_fall_with_done", {31'b0, busy}, 32'd0);
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done within %0d cycles", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  int base_bytes, base_done;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sel", {31'b0, sel_out}, 32'd0);
    check("rst_read", {31'b0, read_out}, 32'd0);
    check("rst_mask", {28'b0, write_mask_out}, 32'd0);
    check("rst_addr", address_out, 32'd0);
    check("rst_wdata", write_value_out, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;

    // First run: init list plus red fill, STATUS busy for 3 reads per byte
    busy_cfg = 3; lat_max = 0;
    base_bytes = byte_cnt; base_done = done_cnt;
    push_run(1, 16'hF800);
    pulse_start(16'hF800);
    wait_done(5000);
    check("run1_bytes", byte_cnt - base_bytes, 32'd24);
    check("run1_done_pulses", done_cnt - base_done, 32'd1);
    check("run1_queue_empty", exp_q.size(), 32'd0);

    // Second run without init; stray start and colour change mid-run are ignored
    busy_cfg = 0;
    base_bytes = byte_cnt; base_done = done_cnt;
    push_run(0, 16'h07E0);
    pulse_start(16'h07E0);
    repeat (40) @(negedge clk);
    color_in = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000);
    repeat (40) @(negedge clk);
    check("run2_bytes", byte_cnt - base_bytes, 32'd19);
    check("run2_done_pulses", done_cnt - base_done, 32'd1);
    check("run2_queue_empty", exp_q.size(), 32'd0);
    check("run2_idle_after", {31'b0, busy}, 32'd0);

    // STATUS held busy for 50 reads per byte
    busy_cfg = 50;
    base_bytes = byte_cnt;
    push_run(0, 16'h001F);
    pulse_start(16'h001F);
    wait_done(10000);
    check("run3_bytes", byte_cnt - base_bytes, 32'd19);
    check("run3_queue_empty", exp_q.size(), 32'd0);

    // Reset during the pixel phase
    busy_cfg = 0;
    base_bytes = byte_cnt;
    push_run(0, 16'hFFFF);
    pulse_start(16'hFFFF);
    for (int i = 0; i < 2000 && (byte_cnt - base_bytes) < 13; i++) @(negedge clk);
    check("reached_pixels", {31'b0, (byte_cnt - base_bytes) >= 13}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_sel", {31'b0, sel_out}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_mask", {28'b0, write_mask_out}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // After reset the init list returns; random slave latency
    busy_cfg = 3; lat_max = 5;
    base_bytes = byte_cnt; base_done = done_cnt;
    push_run(1, 16'hF800);
    pulse_start(16'hF800);
    wait_done(8000);
    check("run4_bytes", byte_cnt - base_bytes, 32'd24);
    check("run4_done_pulses", done_cnt - base_done, 32'd1);
    check("run4_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_fill_sequencer.md
# lcd_fill_sequencer

Bus-master sequencer that sits directly upstream of `spi_controller` and drives its memory-mapped register port, exactly as a CPU would. On a `start` pulse it runs a one-time panel init list, programs the full-screen window, and streams `WIDTH*HEIGHT` RGB565 pixels of a single colour. Each byte goes out through the controller's DC/DATA/CTRL/STATUS registers. The push-button path (`button` → `pressed`) or software connects to `start`.

## Interface
- `WIDTH`, default 240: panel columns.
- `HEIGHT`, default 320: panel rows.
- `DELAY_CYCLES`, default 12_000_000: wait after SWRESET and after SLPOUT (120 ms at 100 MHz).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; ignored while `busy`.
- `color_in` in 16: RGB565 colour, sampled on the accepted `start`.
- `address_out` out 32: register address to `spi_controller`.
- `sel_out` out 1: bus access request.
- `read_out` out 1: 1 = read, 0 = write.
- `write_mask_out` out 4: always 4'b1111 during writes.
- `write_value_out` out 32: write data.
- `read_value_in` in 32: read data from the controller.
- `ready_in` in 1: access complete.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse when the last pixel byte has completed.

## Operation
- Controller register map:
  - 0x0: DATA, bits [7:0] = byte.
  - 0x4: CTRL, bit0 = 1 starts a transfer.
  - 0x8: STATUS, bit0 = transfer busy.
  - 0xC: DC, bit0 = 1 for data, 0 for command.
- Byte issue, every byte, in order:
  1. Write DC = dc bit.
  2. Write DATA = {24'b0, byte}.
  3. Write CTRL = 1.
  4. Read STATUS, repeating until bit0 = 0.
- Init list, sent only on the first run after reset (`init_done` = 0):
  - cmd 0x01, then DELAY.
  - cmd 0x11, then DELAY.
  - cmd 0x3A, data 0x55.
  - cmd 0x29.
  - `init_done` is set after cmd 0x29 completes.
- Every run:
  - cmd 0x2A; data 0x00, 0x00, (WIDTH-1)[15:8], (WIDTH-1)[7:0].
  - cmd 0x2B; data 0x00, 0x00, (HEIGHT-1)[15:8], (HEIGHT-1)[7:0].
  - cmd 0x2C.
  - `WIDTH*HEIGHT` pixels, each sent as data byte color[15:8] then data byte color[7:0].
- FSM states:
  - IDLE → (start) → LOAD: fetch the next {dc, byte} from the step counter.
  - LOAD → WR_DC → WR_DATA → WR_CTRL → POLL.
  - POLL → (bit0 = 1) → POLL_GAP → POLL.
  - POLL → (bit0 = 0) → NEXT.
  - NEXT → DELAY, when the step just sent was 0x01 or 0x11; DELAY counts `DELAY_CYCLES` then goes to LOAD.
  - NEXT → LOAD, when more steps remain.
  - NEXT → FINISH when all steps are sent; FINISH pulses `done` → IDLE.
- Pixel counter width is $clog2(WIDTH*HEIGHT+1). The byte-phase bit toggles per pixel byte. The counter is zero at the start of each run.
- The colour is latched on the accepted `start`. `color_in` changes mid-run have no effect.
- `start` while `busy` = 1 is dropped, not queued.

## Timing
- Reset values:
  - `sel_out` = 0, `read_out` = 0, `write_mask_out` = 0.
  - `address_out` = 0, `write_value_out` = 0.
  - `busy` = 0, `done` = 0.
  - `init_done` = 0; FSM in IDLE.
- Bus handshake:
  - `sel_out` rises with address, data and mask valid, and holds them stable until the posedge where `ready_in` = 1.
  - `sel_out` = 0 on the following cycle.
  - At least one idle cycle separates accesses.
  - Read data is captured on the posedge where `ready_in` = 1.
- `write_mask_out` = 4'b1111 only while `sel_out` = 1 and `read_out` = 0; otherwise 0.
- `busy` rises the cycle after the accepted `start`. It falls in the same cycle `done` pulses.
- POLL_GAP is exactly 1 idle cycle between STATUS reads.
- DELAY lasts exactly `DELAY_CYCLES` clocks with `sel_out` = 0.
- Reset mid-operation takes effect at the next posedge:
  - All outputs return to reset values and `init_done` clears, so the next run re-inits.
  - Any in-flight bus access is abandoned.
- Zero-wait slave (`ready_in` tied 1), per byte with STATUS clear on the first read: 4 accesses + 3 gaps = 7 cycles of bus activity, plus 2 cycles of LOAD/NEXT overhead.

## Test plan
- First run, init + fill:
  - Stimulus: WIDTH=2, HEIGHT=2, DELAY_CYCLES=16, `color_in`=0xF800, zero-wait slave model, STATUS busy for 3 reads.
  - Required response: exactly 24 bytes in order: 01,11,3A,55,29,2A,00,00,00,01,2B,00,00,00,01,2C, then F8,00 ×4.
  - DC = 1 only on the data bytes.
  - Gap ≥ 16 idle cycles after 0x01 and after 0x11.
  - `done` pulses once.
- Second `start` with `color_in`=0x07E0: 19 bytes with no init list; pixel bytes 07,E0 ×4.
- `start` pulsed mid-run: no extra bytes; byte count unchanged.
- Slave with random 0–5 cycle `ready_in` latency:
  - `address_out`, `write_value_out` and `sel_out` are held stable until `ready_in`.
  - Byte stream is identical to scenario 1.
- `reset` asserted during the pixel phase:
  - Next cycle: `sel_out` = 0 and `busy` = 0.
  - A following `start` re-sends the 0x01 init.
- STATUS held busy for 50 reads: 50 reads, each separated by 1 idle cycle, and no DC write until a read returns 0.
